// File: rtl/utx_pkg.sv
// Shared UART transmit frame timing on 1 us granularity: 115200 baud 8N1 approximated by a fixed boundary table.
// Bit edges sit at fixed microsecond counts so every frame is 87 us long, LSB first.
package utx_pkg;

    localparam int unsigned UTX_CNT_W = 7;

    typedef logic [UTX_CNT_W-1:0] cnt_us_t;

    localparam cnt_us_t UTX_FRAME_US = 7'd87;
    localparam cnt_us_t UTX_B0       = 7'd9;
    localparam cnt_us_t UTX_B1       = 7'd17;
    localparam cnt_us_t UTX_B2       = 7'd26;
    localparam cnt_us_t UTX_B3       = 7'd35;
    localparam cnt_us_t UTX_B4       = 7'd43;
    localparam cnt_us_t UTX_B5       = 7'd52;
    localparam cnt_us_t UTX_B6       = 7'd61;
    localparam cnt_us_t UTX_B7       = 7'd69;
    localparam cnt_us_t UTX_STOP     = 7'd78;

    typedef enum logic {
        UTX_IDLE = 1'b0,
        UTX_SEND = 1'b1
    } utx_state_t;

    // Line level after a strobe in SEND, keyed on the count before it increments.
    function automatic logic utx_line_next(input cnt_us_t cnt, input logic [7:0] shreg,
                                           input logic cur);
        logic nxt;
        nxt = cur;
        case (cnt)
            UTX_B0:   nxt = shreg[0];
            UTX_B1:   nxt = shreg[1];
            UTX_B2:   nxt = shreg[2];
            UTX_B3:   nxt = shreg[3];
            UTX_B4:   nxt = shreg[4];
            UTX_B5:   nxt = shreg[5];
            UTX_B6:   nxt = shreg[6];
            UTX_B7:   nxt = shreg[7];
            UTX_STOP: nxt = 1'b1;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/phy_utx_if.sv
// Byte push channel plus status between the protocol layer and the UART transmit PHY.
// tx_rdy gates tx_vld; tx_ovf flags a dropped push, tx_busy covers queued and in-flight bytes.
interface phy_utx_if;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;
    logic       tx_ovf;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_vld,
        input  tx_rdy,
        input  tx_ovf,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_vld,
        output tx_rdy,
        output tx_ovf,
        output tx_busy
    );
endinterface

// File: rtl/utx_fifo.sv
// Single-clock byte FIFO with show-ahead read data; one-cycle write, read data valid while not empty.
// Push when full and pop when empty are ignored, so the caller never corrupts the pointers.
module utx_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB tells full from empty when the address bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign rdata = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wptr[FIFO_AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/phy_utx.sv
// 8N1 UART transmitter paced by the 1 us strobe; start edge leaves 1 clk after the first strobe with a byte queued.
// tx_rdy drops while the FIFO is full; a push then is dropped and flagged one cycle later on tx_ovf.
module phy_utx
    import utx_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic     clk_sys,
    input  logic     rst_n,
    input  logic     pluse_us,
    phy_utx_if.slave bus,
    output logic     uart_tx
);

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_rdata;

    utx_state_t state;
    cnt_us_t    cnt_us;
    logic [7:0] shreg;
    logic       tx_ovf;
    logic       tx_busy;
    logic       frame_end;
    logic       cnt_bad;

    assign frame_end = (state == UTX_SEND) && (cnt_us == UTX_FRAME_US);
    assign cnt_bad   = (cnt_us > UTX_FRAME_US);

    assign fifo_push = bus.tx_vld & ~fifo_full;
    // Pop on the strobe that starts a frame, either from idle or straight after a stop bit.
    assign fifo_pop  = pluse_us & ~fifo_empty & ((state == UTX_IDLE) | frame_end);

    assign bus.tx_rdy  = ~fifo_full;
    assign bus.tx_ovf  = tx_ovf;
    assign bus.tx_busy = tx_busy;

    utx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (bus.tx_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state   <= UTX_IDLE;
            cnt_us  <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
            tx_ovf  <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            tx_ovf  <= bus.tx_vld & fifo_full;
            tx_busy <= (state == UTX_SEND) | ~fifo_empty;
            if (pluse_us) begin
                if (fifo_pop) begin
                    shreg   <= fifo_rdata;
                    uart_tx <= 1'b0;
                    cnt_us  <= 7'd1;
                    state   <= UTX_SEND;
                end else if ((state == UTX_IDLE) || frame_end || cnt_bad) begin
                    // Out-of-range counts are unreachable but recover to a clean idle line.
                    state   <= UTX_IDLE;
                    cnt_us  <= '0;
                    uart_tx <= 1'b1;
                end else begin
                    uart_tx <= utx_line_next(cnt_us, shreg, uart_tx);
                    cnt_us  <= cnt_us + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_utx.sv
// Bench for phy_utx: strobe generator, line decoder that records each frame, and per-scenario tasks.
module tb_phy_utx;

    localparam int CLK_T = 10;

    logic clk_sys  = 1'b0;
    logic rst_n;
    logic pluse_us = 1'b0;
    logic uart_tx;

    phy_utx_if u_if ();

    phy_utx #(
        .FIFO_AW (2)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (pluse_us),
        .bus      (u_if),
        .uart_tx  (uart_tx)
    );

    always #(CLK_T/2) clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Strobe generator: one pulse every pl_div clocks; slots in [skip_lo, skip_hi) are suppressed.
    int pl_div  = 100;
    bit pl_en   = 1'b1;
    int pdiv    = 0;
    int pl_idx  = 0;
    int skip_lo = 0;
    int skip_hi = 0;

    always @(posedge clk_sys) begin
        #1;
        if (pdiv >= pl_div - 1) begin
            pdiv = 0;
            pl_idx++;
            pluse_us = pl_en && !(pl_idx >= skip_lo && pl_idx < skip_hi);
        end else begin
            pdiv++;
            pluse_us = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         shape_ok;
        time        t_start;
        time        t_end;
    } rx_rec_t;

    rx_rec_t    rx_q[$];
    logic [7:0] exp_q[$];

    bit      in_frame    = 1'b0;
    bit      pend        = 1'b0;
    int      pk          = 0;
    int      n_starts    = 0;
    rx_rec_t cur;
    logic    prev_busy   = 1'b0;
    time     t_busy_fall = 0;
    int      bnd [9]     = '{9, 17, 26, 35, 43, 52, 61, 69, 78};

    task automatic mon_start;
        in_frame       = 1'b1;
        pk             = 0;
        cur.data       = 8'h00;
        cur.shape_ok   = 1'b1;
        cur.t_start    = $time;
        cur.t_end      = 0;
        n_starts++;
    endtask

    // Receiver model: counts strobes since the start edge and checks the line against the bit table.
    always @(negedge clk_sys) begin : mon
        bit had_pl;
        int r;
        had_pl = pend;
        pend   = (pluse_us === 1'b1);
        if (prev_busy === 1'b1 && u_if.tx_busy === 1'b0) t_busy_fall = $time;
        prev_busy = u_if.tx_busy;
        if (rst_n !== 1'b1) begin
            in_frame = 1'b0;
        end else if (in_frame) begin
            if (had_pl) pk++;
            if (pk >= 87) begin
                cur.t_end = $time;
                rx_q.push_back(cur);
                if (uart_tx === 1'b0) mon_start();
                else in_frame = 1'b0;
            end else if (pk < 9) begin
                if (uart_tx !== 1'b0) cur.shape_ok = 1'b0;
            end else begin
                r = 0;
                for (int i = 0; i < 9; i++) if (pk >= bnd[i]) r = i;
                if (r == 8) begin
                    if (uart_tx !== 1'b1) cur.shape_ok = 1'b0;
                end else if (pk == bnd[r]) begin
                    cur.data[r] = uart_tx;
                end else if (uart_tx !== cur.data[r]) begin
                    cur.shape_ok = 1'b0;
                end
            end
        end else if (uart_tx === 1'b0) begin
            mon_start();
        end
    end

    task automatic drive(input logic [7:0] b);
        @(posedge clk_sys);
        #1;
        u_if.tx_data = b;
        u_if.tx_vld  = 1'b1;
    endtask

    task automatic release_vld;
        @(posedge clk_sys);
        #1;
        u_if.tx_vld = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int max_clk, output bit ok);
        int k;
        k = 0;
        while (rx_q.size() < n && k < max_clk) begin
            @(negedge clk_sys);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        while ((u_if.tx_busy !== 1'b0 || in_frame) && k < 20000) begin
            @(negedge clk_sys);
            k++;
        end
        ok = (u_if.tx_busy === 1'b0) && !in_frame;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        u_if.tx_vld  = 1'b0;
        u_if.tx_data = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
        @(negedge clk_sys);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (u_if.tx_rdy !== 1'b1) begin errors++; $display("FAIL reset_tx_rdy: got %b expected 1", u_if.tx_rdy); end
        checks++; if (u_if.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", u_if.tx_busy); end
        checks++; if (u_if.tx_ovf !== 1'b0) begin errors++; $display("FAIL reset_tx_ovf: got %b expected 0", u_if.tx_ovf); end
    endtask

    task automatic test_single;
        rx_rec_t    r;
        logic [7:0] e;
        bit         ok;
        time        d;
        pl_div = 100;
        exp_q.push_back(8'h55);
        drive(8'h55);
        release_vld;
        wait_rx(1, 12000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_frame: got %0d frames expected 1", rx_q.size()); end
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e) begin errors++; $display("FAIL single_data: got %h expected %h", r.data, e); end
            checks++; if (r.shape_ok !== 1'b1) begin errors++; $display("FAIL single_bit_widths: got bad shape expected 9,8,9,9,8,9,9,8,9,9 us"); end
            d = r.t_end - r.t_start;
            checks++; if (d !== 87 * 100 * CLK_T) begin errors++; $display("FAIL single_frame_len: got %0t expected %0t", d, 87 * 100 * CLK_T); end
            repeat (3) @(negedge clk_sys);
            d = t_busy_fall - r.t_start;
            checks++; if (d !== 87 * 100 * CLK_T + CLK_T) begin errors++; $display("FAIL single_busy_fall: got %0t expected %0t", d, 87 * 100 * CLK_T + CLK_T); end
            checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b expected 1", uart_tx); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        rx_rec_t    r;
        logic [7:0] e;
        time        prev_start;
        bit         ok;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: got busy expected idle"); end
        pl_div = 10;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bytes[i]);
            drive(bytes[i]);
        end
        release_vld;
        wait_rx(4, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_frames: got %0d frames expected 4", rx_q.size()); end
        prev_start = 0;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (r.data !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, r.data, e); end
                checks++; if (r.shape_ok !== 1'b1) begin errors++; $display("FAIL b2b_shape[%0d]: got bad shape expected table widths", i); end
                if (i > 0) begin
                    checks++;
                    if (r.t_start - prev_start !== 87 * 10 * CLK_T) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0t expected %0t", i, r.t_start - prev_start, 87 * 10 * CLK_T);
                    end
                end
                prev_start = r.t_start;
            end
        end
    endtask

    task automatic test_overflow;
        rx_rec_t    r;
        logic [7:0] e;
        bit         ok;
        int         mdl;
        int         novf;
        logic       exp_rdy;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_idle: got busy expected idle"); end
        pl_en = 1'b0;
        mdl   = 0;
        novf  = 0;
        for (int i = 0; i < 6; i++) begin
            drive(8'h10 + 8'(i));
            @(negedge clk_sys);
            if (u_if.tx_ovf === 1'b1) novf++;
            exp_rdy = (mdl < 4);
            checks++; if (u_if.tx_rdy !== exp_rdy) begin errors++; $display("FAIL ovf_rdy[%0d]: got %b expected %b", i, u_if.tx_rdy, exp_rdy); end
            if (mdl < 4) begin
                exp_q.push_back(8'h10 + 8'(i));
                mdl++;
            end
        end
        release_vld;
        @(negedge clk_sys);
        if (u_if.tx_ovf === 1'b1) novf++;
        @(negedge clk_sys);
        if (u_if.tx_ovf === 1'b1) novf++;
        checks++; if (novf !== 2) begin errors++; $display("FAIL ovf_pulses: got %0d expected 2", novf); end
        checks++; if (u_if.tx_rdy !== 1'b0) begin errors++; $display("FAIL ovf_full_rdy: got %b expected 0", u_if.tx_rdy); end
        pl_en = 1'b1;
        wait_rx(4, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_frames: got %0d frames expected 4", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (r.data !== e) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, r.data, e); end
            end
        end
        repeat (1000) @(negedge clk_sys);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL ovf_extra_frames: got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_reset_mid;
        rx_rec_t    r;
        logic [7:0] e;
        bit         ok;
        int         k;
        int         ns;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: got busy expected idle"); end
        drive(8'h0F);
        drive(8'h33);
        release_vld;
        k = 0;
        while (!(in_frame && pk == 39) && k < 2000) begin
            @(negedge clk_sys);
            k++;
        end
        checks++; if (!(in_frame && pk == 39)) begin errors++; $display("FAIL rstmid_reach: got pk %0d expected 39", pk); end
        @(posedge clk_sys);
        #1 rst_n = 1'b0;
        @(posedge clk_sys);
        #1 rst_n = 1'b1;
        @(negedge clk_sys);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (u_if.tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", u_if.tx_busy); end
        checks++; if (u_if.tx_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy: got %b expected 1", u_if.tx_rdy); end
        ns = n_starts;
        repeat (2000) @(negedge clk_sys);
        checks++; if (n_starts !== ns) begin errors++; $display("FAIL rstmid_quiet: got %0d starts expected %0d", n_starts, ns); end
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rstmid_frames: got %0d expected 0", rx_q.size()); end
        exp_q.push_back(8'h0F);
        drive(8'h0F);
        release_vld;
        wait_rx(1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_resend: got %0d frames expected 1", rx_q.size()); end
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e) begin errors++; $display("FAIL rstmid_data: got %h expected %h", r.data, e); end
        end
    endtask

    task automatic test_freeze;
        rx_rec_t    r;
        logic [7:0] e;
        bit         ok;
        int         k;
        int         bad;
        logic       v;
        int         p;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL freeze_idle: got busy expected idle"); end
        exp_q.push_back(8'h5A);
        drive(8'h5A);
        release_vld;
        k = 0;
        while (!(in_frame && pk == 30) && k < 2000) begin
            @(negedge clk_sys);
            k++;
        end
        skip_lo = pl_idx + 1;
        skip_hi = pl_idx + 51;
        v   = uart_tx;
        p   = pk;
        bad = 0;
        repeat (49 * 10) begin
            @(negedge clk_sys);
            if (uart_tx !== v || pk !== p) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL freeze_hold: got %0d changes expected 0", bad); end
        wait_rx(1, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL freeze_frame: got %0d frames expected 1", rx_q.size()); end
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e) begin errors++; $display("FAIL freeze_data: got %h expected %h", r.data, e); end
            checks++; if (r.shape_ok !== 1'b1) begin errors++; $display("FAIL freeze_shape: got bad shape expected table widths"); end
            checks++; if (r.t_end - r.t_start !== 137 * 10 * CLK_T) begin errors++; $display("FAIL freeze_len: got %0t expected %0t", r.t_end - r.t_start, 137 * 10 * CLK_T); end
        end
    endtask

    task automatic test_idle_latency;
        rx_rec_t    r;
        logic [7:0] e;
        bit         ok;
        int         k;
        time        t_s;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lat_idle: got busy expected idle"); end
        pl_div = 100;
        k = 0;
        while (pluse_us !== 1'b1 && k < 400) begin
            @(negedge clk_sys);
            k++;
        end
        @(posedge clk_sys);
        t_s = $time;
        exp_q.push_back(8'h81);
        drive(8'h81);
        release_vld;
        wait_rx(1, 12000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lat_frame: got %0d frames expected 1", rx_q.size()); end
        if (ok) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (r.data !== e) begin errors++; $display("FAIL lat_data: got %h expected %h", r.data, e); end
            checks++; if (r.t_start !== t_s + 100 * CLK_T + CLK_T / 2) begin errors++; $display("FAIL lat_start: got %0t expected %0t", r.t_start, t_s + 100 * CLK_T + CLK_T / 2); end
        end
    endtask

    initial begin
        #(CLK_T * 90000);
        $display("FAIL watchdog: simulation did not complete within the cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_freeze();
        test_idle_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
